// File: rtl/bos_pkg.sv
// bos_pkg: definitions shared by the slave-side uplink arbiter and the
// round-robin picker. It holds the channel index width, the default
// channel count and start-of-frame byte, the FSM state encoding, and the
// helper that formats the ADDR byte.
package bos_pkg;

  // Channel index width. It covers the maximum of 16 channels.
  localparam int         CH_W     = 4;
  localparam int         N_CH_DEF = 5;
  localparam logic [7:0] SOF_DEF  = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SOF    = 3'd1,
    ST_ADDR   = 3'd2,
    ST_LEN    = 3'd3,
    ST_RD     = 3'd4,
    ST_WAIT_D = 3'd5,
    ST_DATA   = 3'd6,
    ST_CSUM   = 3'd7
  } state_t;

  // The ADDR byte carries the channel number in the low nibble.
  function automatic logic [7:0] addr_byte(input logic [CH_W-1:0] ch);
    return {4'h0, ch};
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin priority encoder.
// The search starts at ptr+1 and wraps. The first set request bit wins.
// Ports:
//   req         in  N     request vector
//   ptr         in  CH_W  last granted index (must be < N)
//   grant_valid out 1     any request present
//   grant_idx   out CH_W  winning index
module rr_pick
  import bos_pkg::*;
#(
  parameter int N = N_CH_DEF
) (
  input  logic [N-1:0]    req,
  input  logic [CH_W-1:0] ptr,
  output logic            grant_valid,
  output logic [CH_W-1:0] grant_idx
);

  logic [2*N-1:0]  w_dbl;
  logic [N-1:0]    w_rot;
  logic [CH_W:0]   w_start;
  logic [CH_W:0]   w_sum;
  logic [CH_W-1:0] w_pos;

  // Doubling the vector turns the wrap into a plain right shift. After the
  // shift, bit 0 of w_rot is the request at ptr+1.
  assign w_dbl   = {req, req};
  assign w_start = {1'b0, ptr} + (CH_W+1)'(1);
  assign w_rot   = N'(w_dbl >> w_start);

  always_comb begin
    w_pos = '0;
    for (int j = N-1; j >= 0; j--) begin
      if (w_rot[j]) w_pos = CH_W'(j);
    end
  end

  // w_sum stays below 2N, so one conditional subtraction does the modulo.
  assign w_sum       = w_start + {1'b0, w_pos};
  assign grant_valid = |req;
  assign grant_idx   = (w_sum >= (CH_W+1)'(N)) ? CH_W'(w_sum - (CH_W+1)'(N))
                                               : w_sum[CH_W-1:0];

endmodule

// File: rtl/slave_tx_arbiter.sv
// slave_tx_arbiter: round-robin scheduler that drains one channel at a time
// onto the byte-wide host uplink as a frame: SOF, ADDR, LEN, payload, and an
// optional checksum.
// Optional feature: define SLAVE_TX_ARB_CSUM_EN to append an XOR checksum.
// The checksum covers ADDR, LEN and all payload bytes.
// Ports:
//   sys_clk, rst        clock; asynchronous active-high reset
//   have_msg_bus[N]     per-channel pending flag
//   len_bus[8N]         per-channel byte count, channel i at [8i+7:8i]
//   slave_data_bus[8N]  FIFO read data, valid the cycle after rdreq
//   rdreq_bus[N]        one-cycle read pulse to the granted channel
//   tx_data/tx_valid    byte to transmitter, held until tx_ready
//   tx_ready            transmitter accept
//   busy                high in every state except IDLE
//   dbg_state           current FSM state encoding
// Handshake: a byte moves when tx_valid & tx_ready at a rising edge. While
// tx_valid is high and tx_ready is low, tx_data and tx_valid do not change.
module slave_tx_arbiter
  import bos_pkg::*;
#(
  parameter int         N_CH = N_CH_DEF,
  parameter logic [7:0] SOF  = SOF_DEF
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   have_msg_bus,
  input  logic [8*N_CH-1:0] len_bus,
  input  logic [8*N_CH-1:0] slave_data_bus,
  output logic [N_CH-1:0]   rdreq_bus,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic [2:0]        dbg_state
);

  state_t          r_state, w_state_nxt;
  logic [CH_W-1:0] r_ch, w_ch_nxt;
  logic [CH_W-1:0] r_ptr, w_ptr_nxt;
  logic [7:0]      r_cnt, w_cnt_nxt;
  logic [7:0]      r_tx_data, w_tx_data_nxt;
  logic            r_tx_valid, w_tx_valid_nxt;
  logic [N_CH-1:0] r_rdreq, w_rdreq_nxt;
`ifdef SLAVE_TX_ARB_CSUM_EN
  logic [7:0]      r_acc, w_acc_nxt;
`endif

  logic            w_grant_valid;
  logic [CH_W-1:0] w_grant_idx;
  logic [7:0]      w_grant_len;
  logic [7:0]      w_rd_data;
  logic [N_CH-1:0] w_onehot;
  logic            w_hs;

  rr_pick #(.N(N_CH)) u_pick (
    .req         (have_msg_bus),
    .ptr         (r_ptr),
    .grant_valid (w_grant_valid),
    .grant_idx   (w_grant_idx)
  );

  // Index the buses with a compare-per-channel mux. This avoids a
  // variable-width part select.
  always_comb begin
    w_grant_len = '0;
    w_rd_data   = '0;
    w_onehot    = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (w_grant_idx == CH_W'(i)) w_grant_len = len_bus[i*8 +: 8];
      if (r_ch == CH_W'(i)) begin
        w_rd_data   = slave_data_bus[i*8 +: 8];
        w_onehot[i] = 1'b1;
      end
    end
  end

  assign w_hs = r_tx_valid & tx_ready;

  // Outputs are registered. Each state computes the byte for the next state.
  always_comb begin
    w_state_nxt    = r_state;
    w_ch_nxt       = r_ch;
    w_ptr_nxt      = r_ptr;
    w_cnt_nxt      = r_cnt;
    w_tx_data_nxt  = r_tx_data;
    w_tx_valid_nxt = r_tx_valid;
    w_rdreq_nxt    = '0;
`ifdef SLAVE_TX_ARB_CSUM_EN
    w_acc_nxt      = r_acc;
`endif
    case (r_state)
      ST_IDLE: begin
        if (w_grant_valid) begin
          w_ch_nxt  = w_grant_idx;
          w_cnt_nxt = w_grant_len;
          // The pointer moves on a zero-length grant too, so an empty
          // requester cannot block the channels after it.
          w_ptr_nxt = w_grant_idx;
          if (w_grant_len != 8'd0) begin
            w_state_nxt    = ST_SOF;
            w_tx_data_nxt  = SOF;
            w_tx_valid_nxt = 1'b1;
`ifdef SLAVE_TX_ARB_CSUM_EN
            w_acc_nxt      = 8'd0;
`endif
          end
        end
      end
      ST_SOF: begin
        if (w_hs) begin
          w_state_nxt   = ST_ADDR;
          w_tx_data_nxt = addr_byte(r_ch);
        end
      end
      ST_ADDR: begin
        if (w_hs) begin
          w_state_nxt   = ST_LEN;
          w_tx_data_nxt = r_cnt;
`ifdef SLAVE_TX_ARB_CSUM_EN
          w_acc_nxt     = r_acc ^ r_tx_data;
`endif
        end
      end
      ST_LEN: begin
        if (w_hs) begin
          w_state_nxt    = ST_RD;
          w_tx_valid_nxt = 1'b0;
          w_rdreq_nxt    = w_onehot;
`ifdef SLAVE_TX_ARB_CSUM_EN
          w_acc_nxt      = r_acc ^ r_tx_data;
`endif
        end
      end
      ST_RD: begin
        w_state_nxt = ST_WAIT_D;
      end
      ST_WAIT_D: begin
        // The FIFO is not show-ahead, so its data is valid now, one cycle
        // after the read pulse.
        w_state_nxt    = ST_DATA;
        w_tx_data_nxt  = w_rd_data;
        w_tx_valid_nxt = 1'b1;
      end
      ST_DATA: begin
        if (w_hs) begin
          w_cnt_nxt = r_cnt - 8'd1;
`ifdef SLAVE_TX_ARB_CSUM_EN
          w_acc_nxt = r_acc ^ r_tx_data;
`endif
          if (r_cnt == 8'd1) begin
`ifdef SLAVE_TX_ARB_CSUM_EN
            w_state_nxt   = ST_CSUM;
            w_tx_data_nxt = r_acc ^ r_tx_data;
`else
            w_state_nxt    = ST_IDLE;
            w_tx_valid_nxt = 1'b0;
`endif
          end else begin
            w_state_nxt    = ST_RD;
            w_tx_valid_nxt = 1'b0;
            w_rdreq_nxt    = w_onehot;
          end
        end
      end
`ifdef SLAVE_TX_ARB_CSUM_EN
      ST_CSUM: begin
        if (w_hs) begin
          w_state_nxt    = ST_IDLE;
          w_tx_valid_nxt = 1'b0;
        end
      end
`endif
      default: begin
        w_state_nxt    = ST_IDLE;
        w_tx_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_ch       <= '0;
      r_ptr      <= CH_W'(N_CH-1);
      r_cnt      <= '0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
      r_rdreq    <= '0;
`ifdef SLAVE_TX_ARB_CSUM_EN
      r_acc      <= '0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_ch       <= w_ch_nxt;
      r_ptr      <= w_ptr_nxt;
      r_cnt      <= w_cnt_nxt;
      r_tx_data  <= w_tx_data_nxt;
      r_tx_valid <= w_tx_valid_nxt;
      r_rdreq    <= w_rdreq_nxt;
`ifdef SLAVE_TX_ARB_CSUM_EN
      r_acc      <= w_acc_nxt;
`endif
    end
  end

  assign rdreq_bus = r_rdreq;
  assign tx_data   = r_tx_data;
  assign tx_valid  = r_tx_valid;
  assign busy      = (r_state != ST_IDLE);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_slave_tx_arbiter.sv
// Testbench for slave_tx_arbiter. The channel FIFOs are modelled as byte
// arrays. A packet-level reference model predicts the full uplink byte
// stream from the loaded FIFO contents and the round-robin rules.
module tb_slave_tx_arbiter;
  import bos_pkg::*;

  localparam int         N      = 5;
  localparam logic [7:0] SOF_B  = 8'hA5;
  localparam int         BUDGET = 20000;
`ifdef SLAVE_TX_ARB_CSUM_EN
  localparam int         CS     = 1;
`else
  localparam int         CS     = 0;
`endif

  // clock / reset
  logic sys_clk = 1'b0;
  logic rst     = 1'b1;
  always #5 sys_clk = ~sys_clk;

  logic [N-1:0]   have_msg_bus;
  logic [8*N-1:0] len_bus;
  logic [8*N-1:0] slave_data_bus = '0;
  logic [N-1:0]   rdreq_bus;
  logic [7:0]     tx_data;
  logic           tx_valid;
  logic           tx_ready = 1'b1;
  logic           busy;
  logic [2:0]     dbg_state;

  slave_tx_arbiter #(.N_CH(N), .SOF(SOF_B)) dut (
    .sys_clk        (sys_clk),
    .rst            (rst),
    .have_msg_bus   (have_msg_bus),
    .len_bus        (len_bus),
    .slave_data_bus (slave_data_bus),
    .rdreq_bus      (rdreq_bus),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .busy           (busy),
    .dbg_state      (dbg_state)
  );

  // channel FIFO model
  logic [7:0]   mem [N][1024];
  int           wr [N];
  int           rd [N];
  int           base [N];
  int           cap [N];
  logic [N-1:0] force_have = '0;
  logic         flush = 1'b0;

  always @(posedge sys_clk) begin
    for (int i = 0; i < N; i++) begin
      if (flush) rd[i] <= wr[i];
      else if (rdreq_bus[i]) begin
        slave_data_bus[i*8 +: 8] <= mem[i][rd[i] & 1023];
        rd[i] <= rd[i] + 1;
      end
    end
  end

  always_comb begin
    have_msg_bus = '0;
    len_bus      = '0;
    for (int i = 0; i < N; i++) begin
      int c;
      c = wr[i] - rd[i];
      have_msg_bus[i]   = (c > 0) || force_have[i];
      len_bus[i*8 +: 8] = 8'((c < cap[i]) ? c : cap[i]);
    end
  end

  // transmitter ready driver
  int hold_low   = 0;
  bit ready_rand = 1'b0;
  always @(posedge sys_clk) begin
    #2;
    if (hold_low > 0) begin
      tx_ready = 1'b0;
      hold_low--;
    end else begin
      tx_ready = ready_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // scoreboard
  logic [7:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  bit sb_en    = 1'b0;
  bit bp_arm   = 1'b0;
  int rd_cnt [N];
  int rd_total, pkts, busy_run, last_busy, stall_cnt;
  int exp_pkts, exp_rd;
  bit prev_stall, prev_busy;
  logic [7:0] prev_data;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge sys_clk) begin
    if (!rst) begin
      if (rdreq_bus != '0) begin
        rd_total++;
        for (int i = 0; i < N; i++) if (rdreq_bus[i]) rd_cnt[i]++;
        if (sb_en) check_eq("rdreq_onehot", 32'($onehot(rdreq_bus)), 1);
      end
      if (busy && !prev_busy) pkts++;
      if (busy) busy_run++;
      else if (prev_busy) begin
        last_busy = busy_run;
        busy_run  = 0;
      end
      prev_busy = busy;
      if (sb_en && prev_stall) begin
        check_eq("hold_valid", 32'(tx_valid), 1);
        check_eq("hold_data", 32'(tx_data), 32'(prev_data));
      end
      prev_stall = tx_valid & !tx_ready;
      prev_data  = tx_data;
      if (sb_en && prev_stall) stall_cnt++;
      if (bp_arm && dbg_state == ST_WAIT_D) begin
        hold_low = 5;
        bp_arm   = 1'b0;
      end
      if (sb_en && tx_valid && tx_ready) begin
        check_eq("byte_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) check_eq("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
      end
    end else begin
      prev_stall = 1'b0;
      prev_busy  = 1'b0;
      busy_run   = 0;
    end
  end

  // Reference model: packet-level round robin over the loaded FIFO contents.
  task automatic model_build();
    int cnt [N];
    int rp [N];
    int ptr, idx, l;
    bit any;
    logic [7:0] acc, b;
    ptr = N - 1;
    exp_pkts = 0;
    exp_rd = 0;
    for (int i = 0; i < N; i++) begin
      cnt[i] = wr[i] - base[i];
      rp[i]  = base[i];
    end
    for (int guard = 0; guard < 10000; guard++) begin
      any = 1'b0;
      for (int i = 0; i < N; i++) if (cnt[i] > 0) any = 1'b1;
      if (!any) break;
      idx = -1;
      for (int k = 1; k <= N; k++) begin
        int j;
        j = (ptr + k) % N;
        if (idx < 0 && (cnt[j] > 0 || force_have[j])) idx = j;
      end
      ptr = idx;
      l = (cnt[idx] < cap[idx]) ? cnt[idx] : cap[idx];
      if (l == 0) continue;
      exp_pkts++;
      exp_rd += l;
      exp_q.push_back(SOF_B);
      exp_q.push_back(8'(idx));
      exp_q.push_back(8'(l));
      acc = 8'(idx) ^ 8'(l);
      for (int m = 0; m < l; m++) begin
        b = mem[idx][(rp[idx] + m) & 1023];
        exp_q.push_back(b);
        acc ^= b;
      end
      if (CS != 0) exp_q.push_back(acc);
      rp[idx] += l;
      cnt[idx] -= l;
    end
  endtask

  // driver tasks
  task automatic begin_test();
    rst   = 1'b1;
    sb_en = 1'b0;
    flush = 1'b1;
    @(posedge sys_clk);
    @(negedge sys_clk);
    flush      = 1'b0;
    force_have = '0;
    for (int i = 0; i < N; i++) begin
      base[i]   = wr[i];
      cap[i]    = 255;
      rd_cnt[i] = 0;
    end
    rd_total   = 0;
    pkts       = 0;
    last_busy  = 0;
    stall_cnt  = 0;
    hold_low   = 0;
    ready_rand = 1'b0;
    bp_arm     = 1'b0;
    exp_q.delete();
  endtask

  task automatic load(input int ch, input logic [7:0] b);
    mem[ch][wr[ch] & 1023] = b;
    wr[ch]++;
  endtask

  task automatic run_test(input string name);
    int cyc;
    model_build();
    sb_en = 1'b1;
    @(negedge sys_clk);
    rst = 1'b0;
    cyc = 0;
    while (cyc < BUDGET && (exp_q.size() != 0 || busy)) begin
      @(negedge sys_clk);
      cyc++;
    end
    check_eq({name, "_in_budget"}, 32'(cyc < BUDGET), 1);
    repeat (20) @(negedge sys_clk);
    check_eq({name, "_left"}, 32'(exp_q.size()), 0);
    check_eq({name, "_rdreqs"}, 32'(rd_total), 32'(exp_rd));
    check_eq({name, "_pkts"}, 32'(pkts), 32'(exp_pkts));
  endtask

  initial begin
    int cyc, nch;
    for (int i = 0; i < N; i++) begin
      wr[i] = 0; base[i] = 0; cap[i] = 255; rd_cnt[i] = 0;
    end
    repeat (3) @(negedge sys_clk);
    check_eq("rst_tx_valid", 32'(tx_valid), 0);
    check_eq("rst_tx_data", 32'(tx_data), 0);
    check_eq("rst_rdreq", 32'(rdreq_bus), 0);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_state", 32'(dbg_state), 32'(ST_IDLE));

    // single channel, ready tied high
    begin_test();
    load(2, 8'h11); load(2, 8'h22); load(2, 8'h33);
    run_test("single");
    check_eq("single_ch2_rdreqs", 32'(rd_cnt[2]), 3);
    check_eq("single_busy_cycles", 32'(last_busy), 32'(3 + 9 + CS));

    // round robin between ch0 and ch4, one byte per grant
    begin_test();
    load(0, 8'h10); load(0, 8'h20); load(4, 8'h40); load(4, 8'h50);
    cap[0] = 1; cap[4] = 1;
    run_test("rr");

    // zero-length requester on ch1 followed by ch3
    begin_test();
    force_have[1] = 1'b1;
    load(3, 8'h31); load(3, 8'h32); load(3, 8'h33);
    run_test("zero_len");
    check_eq("zero_len_ch1_rdreqs", 32'(rd_cnt[1]), 0);

    // five-cycle backpressure on the first payload byte
    begin_test();
    for (int m = 0; m < 6; m++) load(1, 8'(8'hC0 + m));
    bp_arm = 1'b1;
    run_test("backpressure");
    check_eq("bp_stall_cycles", 32'(stall_cnt), 5);

    // asynchronous reset during the payload of a 10-byte packet
    begin_test();
    for (int m = 0; m < 10; m++) load(2, 8'($urandom_range(0, 255)));
    @(negedge sys_clk);
    rst = 1'b0;
    cyc = 0;
    while (cyc < 2000 && !(rd_total >= 3 && dbg_state == ST_DATA)) begin
      @(negedge sys_clk);
      cyc++;
    end
    check_eq("midrst_reached_data", 32'(cyc < 2000), 1);
    @(posedge sys_clk);
    #3 rst = 1'b1;
    #1;
    check_eq("midrst_tx_valid", 32'(tx_valid), 0);
    check_eq("midrst_tx_data", 32'(tx_data), 0);
    check_eq("midrst_rdreq", 32'(rdreq_bus), 0);
    check_eq("midrst_busy", 32'(busy), 0);
    begin_test();
    load(3, 8'h3A); load(3, 8'h3B); load(1, 8'h1A); load(1, 8'h1B);
    run_test("post_reset");

    // saturated length: 300 bytes go out as 255 + 45
    begin_test();
    for (int m = 0; m < 300; m++) load(0, 8'($urandom_range(0, 255)));
    run_test("len255");
    check_eq("len255_ch0_rdreqs", 32'(rd_cnt[0]), 300);

    // randomized mixes with random backpressure
    for (int t = 0; t < 6; t++) begin
      begin_test();
      ready_rand = 1'b1;
      nch = 0;
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 1) == 1) begin
          int n;
          n = $urandom_range(1, 20);
          for (int m = 0; m < n; m++) load(i, 8'($urandom_range(0, 255)));
          cap[i] = ($urandom_range(0, 1) == 1) ? 255 : $urandom_range(1, 4);
          nch++;
        end else if ($urandom_range(0, 3) == 0) begin
          force_have[i] = 1'b1;
        end
      end
      if (nch == 0) load(t % N, 8'(t));
      run_test("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
